// File: rtl/crc_misr_sched.sv
// Session scheduler for the 32-bit CRC/MISR signature: round-robin grant, seed, compact, check.
// Optional: define MISR_INVERT_EN for the inverted-NOR register form of the signature update.
module crc_misr_sched #(
  parameter int          LEN_W = 16,
  parameter logic [31:0] POLY  = 32'h0000_8409
) (
  input  logic               CK,
  input  logic               RESET,
  input  logic [1:0]         req_valid,
  input  logic [2*LEN_W-1:0] req_len,
  input  logic [31:0]        cfg_seed,
  input  logic [31:0]        gold,
  input  logic [31:0]        din0,
  input  logic [31:0]        din1,
  input  logic [1:0]         din_valid,
  output logic [1:0]         din_ready,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic [31:0]        sig,
  output logic               done,
  output logic               done_id,
  output logic               pass
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

  state_t             state_q, state_d;
  logic [31:0]        sig_q, sig_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               gidx_q, gidx_d;
  logic               last_q, last_d;
  logic               done_id_q, done_id_d;
  logic               pass_q, pass_d;

  logic               pick;
  logic [31:0]        din_g;
  logic               fb;
  logic [31:0]        sh;
  logic [31:0]        misr_next;

  // Bit 0 of the feedback mask is forced: the MSB always wraps into bit 0.
  always_comb begin
    din_g = gidx_q ? din1 : din0;
    fb    = sig_q[31];
    sh    = {sig_q[30:0], 1'b0} ^ ({32{fb}} & {POLY[31:1], 1'b1});
`ifdef MISR_INVERT_EN
    misr_next = ~(sh ^ din_g);
`else
    misr_next = sh ^ din_g;
`endif
    pick = req_valid[0] ? (req_valid[1] & ~last_q) : 1'b1;
  end

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    done_id_d = done_id_q;
    pass_d    = pass_q;
    gnt       = 2'b00;
    din_ready = 2'b00;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gidx_d  = pick;
          sig_d   = cfg_seed;
          cnt_d   = '0;
          len_d   = pick ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
          state_d = (len_d != '0) ? RUN : CHECK;
        end
      end
      RUN: begin
        gnt[gidx_q]       = 1'b1;
        din_ready[gidx_q] = 1'b1;
        if (din_valid[gidx_q]) begin
          sig_d = misr_next;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = CHECK;
        end
      end
      CHECK: begin
        done      = 1'b1;
        pass_d    = (sig_q == gold);
        done_id_d = gidx_q;
        last_d    = gidx_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // last_q resets to 1 so that requester 0 wins the first contested grant.
  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      sig_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      gidx_q    <= 1'b0;
      last_q    <= 1'b1;
      done_id_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      done_id_q <= done_id_d;
      pass_q    <= pass_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign sig     = sig_q;
  assign done_id = done_id_q;
  assign pass    = pass_q;

endmodule

// File: doc/crc_misr_sched.md
Name: crc_misr_sched

Overview:
- Session scheduler and sequencer for the 32-bit CRC/MISR signature datapath of the s35932 test-compaction logic.
- Arbitrates between two requesters, such as scan/response streams. Each grant covers a whole compaction session.
- Per session: loads the seed, compacts the granted requester's words one per handshake, then compares the final signature against a golden value.
- Sits between the response sources and BIST status/readout logic.

Parameters:
- LEN_W, 16, width of per-session word-count fields.
- POLY, 32'h0000_8409, Galois feedback mask. Feedback from bit 31 is applied at bits 0, 3, 10, 15.

Ports:
- CK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- req_valid  input  2  session request; bit i belongs to requester i.
- req_len  input  2*LEN_W  word count; requester i uses bits [i*LEN_W +: LEN_W].
- cfg_seed  input  32  seed loaded into the signature at grant.
- gold  input  32  expected signature, sampled in CHECK.
- din0  input  32  data word from requester 0.
- din1  input  32  data word from requester 1.
- din_valid  input  2  per-requester data valid.
- din_ready  output  2  per-requester data ready; only the granted bit can be 1.
- gnt  output  2  one-hot grant, held for the whole session.
- busy  output  1  high when state is not IDLE.
- sig  output  32  current signature register.
- done  output  1  one-cycle pulse at session end.
- done_id  output  1  requester index of the last completed session.
- pass  output  1  result of (sig == gold) for the last completed session.

Behaviour:
- Reset values: state IDLE, sig 0, gnt 0, din_ready 0, busy 0, done 0, done_id 0, pass 0, round-robin pointer favours requester 0. A reset mid-session aborts the session immediately; no done pulse is produced.
- States: IDLE, RUN, CHECK.
- IDLE:
  - req_valid is sampled only here.
  - One requester pending: grant it.
  - Both pending: grant the one that was not served last. After reset, requester 0 wins.
  - On grant: gnt<=onehot(g), sig<=cfg_seed, cnt<=0, len<=req_len[g].
  - Next state is RUN if len!=0, else CHECK (an empty session checks the seed).
- RUN:
  - din_ready[g]=1, other ready bit 0.
  - Each handshake (din_valid[g] & din_ready[g]) updates sig and increments cnt.
  - Handshake with cnt==len-1: go to CHECK.
  - No handshake: hold sig and cnt (stalls are unbounded).
  - The non-granted requester's valid and data are ignored.
- Signature update, Galois MISR:
  - fb = sig[31].
  - sh[0] = fb.
  - sh[i] = sig[i-1] ^ (POLY[i] & fb) for i = 1..31.
  - sig_next = sh ^ din_g.
- CHECK (exactly one cycle):
  - gnt=0 and din_ready=0 during this cycle.
  - done=1; pass<=(sig==gold); done_id<=g; pointer<=g.
  - Next state IDLE.
  - pass and done_id hold until the next done.
  - sig holds its final value until the next grant.
- Latency: len=N with no stalls gives grant-to-done of N+1 cycles; the next grant can occur 1 cycle after done.
- A requester that keeps req_valid high is served again, alternating with the other requester if both are requesting.
- req_len and cfg_seed changes after grant have no effect on the current session.
- The counter is LEN_W bits; len = 2^LEN_W-1 is the largest legal session.

Optional Feature:
- Macro: MISR_INVERT_EN.
- Defined: sig_next = ~(sh ^ din_g), matching the inverted-NOR register form of the gate-level signature. The seed is loaded uninverted, and the compare uses the inverted-form signature.
- Undefined: sig_next = sh ^ din_g exactly as above.

Test Plan:
- Single word: cfg_seed=0, req0 len=1, din0=0x00000001 -> sig=0x00000001, done with done_id=0; gold=0x00000001 -> pass=1.
- Feedback: cfg_seed=0x80000000, req1 len=2, din1=0, 0 -> sig=0x00008409 after word 1, 0x00010812 after word 2; gold=0x00010813 -> pass=0, done_id=1.
- Arbitration: req_valid=2'b11 after reset, both len=1 -> first grant 01, second grant 10; keep both high -> grants alternate 01,10,01.
- Stalls and ignore: granted req0 len=3 with valid gaps, req1 toggling data -> sig depends only on din0; done exactly after the 3rd handshake; din_ready[1]=0 throughout.
- Empty session and abort: len=0, cfg_seed=0x1234ABCD, gold equal -> done after 1 cycle, pass=1. Assert RESET mid-RUN -> all outputs 0, state IDLE, no done pulse.
- MISR_INVERT_EN: cfg_seed=0, len=1, din=0 -> sig=0xFFFFFFFF.
